// File: rtl/vga_timing_rx_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_rx_pkg
// Shared VGA timing constants (640x480 @ 800x521 raster), lock FSM state
// encoding and the saturating counter helper, used by both the timing
// generator and the receiver.
// -----------------------------------------------------------------------------
package vga_timing_rx_pkg;

    // Counter / measurement width and its saturation value
    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Standard 640x480 raster
    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned V_TOTAL = 521;
    localparam int unsigned H_PULSE = 96;
    localparam int unsigned V_PULSE = 2;
    localparam int unsigned H_BP    = 144;
    localparam int unsigned H_FP    = 784;
    localparam int unsigned V_BP    = 31;
    localparam int unsigned V_FP    = 511;

    // Lock FSM states
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_e;

    // Increment that sticks at CNT_MAX instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_MAX) ? x : x + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchronizer for an asynchronous active-low sync pulse, followed
// by a history flop; flags the falling edge of the synchronized level.
//   clk     pixel clock
//   clr     synchronous active-high reset (flops load the idle level 1)
//   din     asynchronous sync input
//   fall_c  combinational falling-edge strobe (history=1, synced=0)
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic fall_c
);

    logic [1:0] sync;
    logic       hist;

    // Synchronizer and history; reset to idle-high so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (clr) begin
            sync <= 2'b11;
            hist <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            hist <= sync[1];
        end
    end

    assign fall_c = hist & ~sync[1];

endmodule

// File: rtl/vga_timing_rx.sv
// -----------------------------------------------------------------------------
// vga_timing_rx
// Recovers pixel/line position from incoming VGA hsync/vsync, measures the
// line length and frame height, and declares lock once the timing has been
// stable for LOCK_FRAMES consecutive frames.
//   clk          pixel clock
//   clr          synchronous active-high reset
//   hsync_in     asynchronous active-low horizontal sync
//   vsync_in     asynchronous active-low vertical sync
//   hc, vc       recovered column / line counters (saturate at 1023)
//   active       registered active-video flag (one cycle after hc/vc)
//   locked       registered, high exactly while the lock FSM is LOCKED
//   line_len     last measured clocks per line
//   frame_lines  last measured lines per frame
// -----------------------------------------------------------------------------
module vga_timing_rx
    import vga_timing_rx_pkg::*;
#(
    parameter int unsigned HBP         = H_BP,
    parameter int unsigned HFP         = H_FP,
    parameter int unsigned VBP         = V_BP,
    parameter int unsigned VFP         = V_FP,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             active,
    output logic             locked,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines
);

    localparam int unsigned FC_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] HBP_V = CNT_W'(HBP);
    localparam logic [CNT_W-1:0] HFP_V = CNT_W'(HFP);
    localparam logic [CNT_W-1:0] VBP_V = CNT_W'(VBP);
    localparam logic [CNT_W-1:0] VFP_V = CNT_W'(VFP);

    logic hfall_c;
    logic vfall_c;

    lock_state_e      state;
    lock_state_e      state_n;
    logic [FC_W-1:0]  frm_cnt;
    logic [FC_W-1:0]  frm_cnt_n;

    logic [CNT_W-1:0] ref_len;        // first line length of the current frame
    logic             first_pending;  // no line measured yet in this frame
    logic             line_bad;       // a line in this frame differed from ref_len

    logic             hc_sat_c;
    logic [CNT_W-1:0] hc_meas_c;
    logic [CNT_W-1:0] vc_meas_c;
    logic             line_mis_c;
    logic             frame_bad_c;
    logic             win_c;

    sync_edge_det u_hs_det (
        .clk    (clk),
        .clr    (clr),
        .din    (hsync_in),
        .fall_c (hfall_c)
    );

    sync_edge_det u_vs_det (
        .clk    (clk),
        .clr    (clr),
        .din    (vsync_in),
        .fall_c (vfall_c)
    );

    // Measurements taken at sync edges; hc+1 only used when hc is not saturated
    always_comb begin
        hc_sat_c    = (hc == CNT_MAX);
        hc_meas_c   = hc + CNT_W'(1);
        vc_meas_c   = sat_inc(vc);
        line_mis_c  = hfall_c && !hc_sat_c && !first_pending && (hc_meas_c != ref_len);
        frame_bad_c = line_bad || line_mis_c;
        win_c       = (hc >= HBP_V) && (hc < HFP_V) && (vc >= VBP_V) && (vc < VFP_V);
    end

    // Column/line counters and measurement registers
    always_ff @(posedge clk) begin
        if (clr) begin
            hc          <= '0;
            vc          <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            if (hfall_c) begin
                hc <= '0;
                if (!hc_sat_c) begin
                    line_len <= hc_meas_c;
                end
            end else begin
                hc <= sat_inc(hc);
            end

            // vsync wins over a coincident hsync for vc
            if (vfall_c) begin
                vc          <= '0;
                frame_lines <= vc_meas_c;
            end else if (hfall_c) begin
                vc <= sat_inc(vc);
            end
        end
    end

    // Per-frame line-length consistency tracking; a coincident hsync edge
    // closes the old frame before vsync opens the new one
    always_ff @(posedge clk) begin
        if (clr) begin
            ref_len       <= '0;
            first_pending <= 1'b1;
            line_bad      <= 1'b0;
        end else begin
            if (hfall_c && !hc_sat_c && first_pending) begin
                ref_len       <= hc_meas_c;
                first_pending <= 1'b0;
            end else if (line_mis_c) begin
                line_bad <= 1'b1;
            end

            if (vfall_c) begin
                first_pending <= 1'b1;
                line_bad      <= 1'b0;
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= ST_SEARCH;
            frm_cnt <= '0;
            locked  <= 1'b0;
        end else begin
            state   <= state_n;
            frm_cnt <= frm_cnt_n;
            locked  <= (state_n == ST_LOCKED);
        end
    end

    // Lock FSM next state; a saturated hc means sync is lost in every state.
    // The first frame after entering VERIFY has no trusted predecessor, so
    // its height is recorded but not compared.
    always_comb begin
        state_n   = state;
        frm_cnt_n = frm_cnt;

        if (hc_sat_c) begin
            state_n   = ST_SEARCH;
            frm_cnt_n = '0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (vfall_c) begin
                        state_n   = ST_VERIFY;
                        frm_cnt_n = '0;
                    end
                end
                ST_VERIFY: begin
                    if (vfall_c) begin
                        if (!frame_bad_c && ((frm_cnt == '0) || (vc_meas_c == frame_lines))) begin
                            if ((32'(frm_cnt) + 32'd1) >= LOCK_FRAMES) begin
                                state_n   = ST_LOCKED;
                                frm_cnt_n = '0;
                            end else begin
                                frm_cnt_n = frm_cnt + FC_W'(1);
                            end
                        end else begin
                            frm_cnt_n = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (line_mis_c || (vfall_c && (vc_meas_c != frame_lines))) begin
                        state_n   = ST_SEARCH;
                        frm_cnt_n = '0;
                    end
                end
                default: begin
                    state_n   = ST_SEARCH;
                    frm_cnt_n = '0;
                end
            endcase
        end
    end

    // Active window, judged on the current hc/vc and lock status
    always_ff @(posedge clk) begin
        if (clr) begin
            active <= 1'b0;
        end else begin
            active <= locked && win_c;
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_rx
// Directed bench for vga_timing_rx on a scaled-down raster (40 clocks x 25
// lines) so that lock, loss of lock and relock all fit in a short run.
// A behavioural model predicts every output each cycle; literal expectations
// at hand-computed edges pin the model.
// -----------------------------------------------------------------------------
module tb_vga_timing_rx;
    import vga_timing_rx_pkg::*;

    localparam int G_HT   = 40;
    localparam int G_VT   = 25;
    localparam int G_HP   = 4;
    localparam int G_VP   = 2;
    localparam int T_HBP  = 10;
    localparam int T_HFP  = 34;
    localparam int T_VBP  = 4;
    localparam int T_VFP  = 22;
    localparam int T_LOCK = 2;
    localparam int SAT    = 1023;

    logic       clk = 1'b0;
    logic       clr;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       active;
    logic       locked;
    logic [9:0] line_len;
    logic [9:0] frame_lines;

    vga_timing_rx #(
        .HBP         (T_HBP),
        .HFP         (T_HFP),
        .VBP         (T_VBP),
        .VFP         (T_VFP),
        .LOCK_FRAMES (T_LOCK)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hc          (hc),
        .vc          (vc),
        .active      (active),
        .locked      (locked),
        .line_len    (line_len),
        .frame_lines (frame_lines)
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_err   = 0;
    int edge_no = 0;
    int base    = 0;
    bit cmp_en  = 1'b0;
    int act_cnt = 0;
    int win_lo  = -1;
    int win_hi  = -1;

    always @(posedge clk) edge_no <= edge_no + 1;

    // ---------------- sync generator ----------------
    bit gen_on    = 1'b0;
    bit hs_kill   = 1'b0;
    bit short_req = 1'b0;
    int gh        = 0;
    int gv        = 0;
    int cur_len   = G_HT;

    task automatic gen_step();
        if (gen_on) begin
            hsync_in = hs_kill ? 1'b1 : (gh >= G_HP);
            vsync_in = (gv >= G_VP);
            if (gh == cur_len - 1) begin
                gh = 0;
                gv = (gv == G_VT - 1) ? 0 : gv + 1;
                if (short_req && gv == 10) begin
                    cur_len   = G_HT - 1;
                    short_req = 1'b0;
                end else begin
                    cur_len = G_HT;
                end
            end else begin
                gh++;
            end
        end else begin
            hsync_in = 1'b1;
            vsync_in = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        gen_step();
    endtask

    task automatic run_to(input int e);
        while (edge_no < e) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no - base);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_hc = 0, m_vc = 0, m_ll = 0, m_fl = 0, m_good = 0;
    bit  m_locked = 1'b0, m_active = 1'b0, m_verify = 1'b0;
    int  frame_lens[$];
    bit [2:0] hh = 3'b111;   // [0]=last sample, [2]=three samples ago
    bit [2:0] vh = 3'b111;

    always @(posedge clk) begin : model
        bit hf, vf, sat, bad_line, ok, nxt_active;
        int fl_meas, len;
        if (clr) begin
            m_hc = 0; m_vc = 0; m_ll = 0; m_fl = 0; m_good = 0;
            m_locked = 1'b0; m_active = 1'b0; m_verify = 1'b0;
            hh = 3'b111; vh = 3'b111;
            frame_lens.delete();
        end else begin
            hf = hh[2] && !hh[1];
            vf = vh[2] && !vh[1];
            hh = {hh[1:0], hsync_in};
            vh = {vh[1:0], vsync_in};
            sat = (m_hc == SAT);
            nxt_active = m_locked && m_hc >= T_HBP && m_hc < T_HFP && m_vc >= T_VBP && m_vc < T_VFP;
            bad_line = 1'b0;
            if (hf && !sat) begin
                len = m_hc + 1;
                if (frame_lens.size() > 0 && len != frame_lens[0]) bad_line = 1'b1;
                frame_lens.push_back(len);
                m_ll = len;
            end
            fl_meas = (m_vc + 1 > SAT) ? SAT : m_vc + 1;
            if (sat) begin
                m_locked = 1'b0; m_verify = 1'b0; m_good = 0;
            end else if (m_locked) begin
                if (bad_line || (vf && fl_meas != m_fl)) begin
                    m_locked = 1'b0; m_good = 0;
                end
            end else if (vf) begin
                if (!m_verify) begin
                    m_verify = 1'b1; m_good = 0;
                end else begin
                    ok = 1'b1;
                    foreach (frame_lens[i]) if (frame_lens[i] != frame_lens[0]) ok = 1'b0;
                    if (m_good > 0 && fl_meas != m_fl) ok = 1'b0;
                    if (ok) m_good++; else m_good = 0;
                    if (m_good >= T_LOCK) begin
                        m_locked = 1'b1; m_verify = 1'b0; m_good = 0;
                    end
                end
            end
            if (vf) frame_lens.delete();
            if (hf) m_hc = 0; else if (m_hc < SAT) m_hc++;
            if (vf) begin m_fl = fl_meas; m_vc = 0; end
            else if (hf && m_vc < SAT) m_vc++;
            m_active = nxt_active;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            n_vec++;
            if (hc !== 10'(m_hc) || vc !== 10'(m_vc) || line_len !== 10'(m_ll) ||
                frame_lines !== 10'(m_fl) || locked !== m_locked || active !== m_active) begin
                n_err++;
                $display("FAIL model edge %0d: hc/vc/ll/fl/lk/ac got %0d/%0d/%0d/%0d/%0b/%0b expected %0d/%0d/%0d/%0d/%0b/%0b",
                         edge_no - base, hc, vc, line_len, frame_lines, locked, active,
                         m_hc, m_vc, m_ll, m_fl, m_locked, m_active);
            end
            if (edge_no >= win_lo && edge_no <= win_hi && active === 1'b1) act_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        clr = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hc", int'(hc), 0);
        check("rst_vc", int'(vc), 0);
        check("rst_line_len", int'(line_len), 0);
        check("rst_frame_lines", int'(frame_lines), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_active", int'(active), 0);
        cmp_en = 1'b1;

        // release reset and start the raster at its origin
        base = edge_no; clr = 1'b0; gen_on = 1'b1; gen_step();

        run_to(base + 3);            // coincident hsync/vsync falls
        check("sim_hc", int'(hc), 0);
        check("sim_vc", int'(vc), 0);
        check("sim_line_len", int'(line_len), 3);
        check("sim_frame_lines", int'(frame_lines), 1);

        run_to(base + 1003);
        check("line_len_40", int'(line_len), 40);
        check("frame_lines_25", int'(frame_lines), 25);

        run_to(base + 2002);
        check("pre_lock", int'(locked), 0);
        win_lo = base + 2004; win_hi = base + 3003;
        run_to(base + 2003);
        check("lock_rise", int'(locked), 1);

        run_to(base + 2173);
        check("active_before_first", int'(active), 0);
        run_to(base + 2174);
        check("active_first", int'(active), 1);

        run_to(base + 3004);
        check("active_per_frame", act_cnt, 432);
        short_req = 1'b1;

        run_to(base + 3441);
        check("locked_before_short", int'(locked), 1);
        run_to(base + 3442);
        check("locked_after_short", int'(locked), 0);

        run_to(base + 6001);
        check("relock_pending", int'(locked), 0);
        run_to(base + 6002);
        check("relock", int'(locked), 1);

        run_to(base + 6500);
        hs_kill = 1'b1;
        run_to(base + 7600);
        check("hc_saturated", int'(hc), 1023);
        check("sat_locked", int'(locked), 0);
        check("sat_line_len", int'(line_len), 40);
        check("sat_frame_lines", int'(frame_lines), 13);
        hs_kill = 1'b0;

        run_to(base + 10500);
        check("locked_before_clr", int'(locked), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; gen_step();
        check("clr_hc", int'(hc), 0);
        check("clr_vc", int'(vc), 0);
        check("clr_line_len", int'(line_len), 0);
        check("clr_frame_lines", int'(frame_lines), 0);
        check("clr_locked", int'(locked), 0);
        check("clr_active", int'(active), 0);

        run_to(base + 13001);
        check("clr_relock_pending", int'(locked), 0);
        run_to(base + 13002);
        check("clr_relock", int'(locked), 1);

        run_to(base + 13050);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
